// File: rtl/wfq_pkg.sv
// Shared types and helpers for the WFQ rank pipeline.
// Holds the default field widths, the per-class finish-tag struct and the
// PIFO rank-word packing helper.
package wfq_pkg;

  localparam int WFQ_CLASS_WIDTH  = 5;
  localparam int WFQ_QUOT_WIDTH   = 16;
  localparam int WFQ_OVF_WIDTH    = 1;
  localparam int WFQ_ROUND_WIDTH  = 18;
  localparam int WFQ_ADDR_WIDTH   = 12;
  localparam int WFQ_RESULT_WIDTH = 32;

  localparam int CLASS_COUNT = 2 ** WFQ_CLASS_WIDTH;
  localparam int ROUND_MAX   = 2 ** WFQ_ROUND_WIDTH - 1;

  // Finish tag of one class: wrap epoch above the round number.
  typedef struct packed {
    logic [WFQ_OVF_WIDTH-1:0]   epoch;
    logic [WFQ_ROUND_WIDTH-1:0] round;
  } wfq_state_t;

  // Rank word handed to the PIFO: marker bit, tag, zeroed address field.
  function automatic logic [WFQ_RESULT_WIDTH-1:0] pack_rank(input wfq_state_t tag);
    return {1'b1, tag.epoch, tag.round, {WFQ_ADDR_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/wfq_rank_pipe_if.sv
// Request/response handshake bundle of the WFQ rank pipeline.
// master: the side issuing requests and consuming ranks.
// slave : the rank pipeline itself.
interface wfq_rank_pipe_if
  import wfq_pkg::*;
#(
  parameter int CLASS_WIDTH  = WFQ_CLASS_WIDTH,
  parameter int QUOT_WIDTH   = WFQ_QUOT_WIDTH,
  parameter int RESULT_WIDTH = WFQ_RESULT_WIDTH
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic [CLASS_WIDTH-1:0]  req_class_id;
  logic [QUOT_WIDTH-1:0]   req_quotient;
  logic [QUOT_WIDTH-1:0]   req_remain;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [RESULT_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_class_id, req_quotient, req_remain, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_class_id, req_quotient, req_remain, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/wfq_rank_calc.sv
// Combinational finish-tag update for one request: picks the base tag
// (class tag, or virtual time when the class has gone stale), adds the
// quantised packet cost, then handles round wrap and lag clamping.
module wfq_rank_calc
  import wfq_pkg::*;
#(
  parameter int QUOT_WIDTH = WFQ_QUOT_WIDTH
) (
  input  wfq_state_t                 cls_state,
  input  logic [WFQ_OVF_WIDTH-1:0]   vt_epoch,
  input  logic [WFQ_ROUND_WIDTH-1:0] vt_round,
  input  logic [QUOT_WIDTH-1:0]      quotient,
  input  logic [QUOT_WIDTH-1:0]      remain,
  output wfq_state_t                 next_state
);

  localparam int RW = WFQ_ROUND_WIDTH;
  localparam logic [RW+1:0] WRAP_LIMIT = (RW+2)'(ROUND_MAX);

  // A wrapped sum stays below 2*(ROUND_MAX+1) because the cost is narrower
  // than a round, so dropping bit RW is the same as subtracting ROUND_MAX+1.
  function automatic wfq_state_t advance_tag(input wfq_state_t cls,
                                             input wfq_state_t vt,
                                             input logic [RW:0] cost);
    wfq_state_t    base;
    wfq_state_t    nxt;
    logic [RW+1:0] sum;
    base = ((cls.epoch != vt.epoch) && (vt.round < cls.round)) ? vt : cls;
    sum  = (RW+2)'(base.round) + (RW+2)'(cost);
    nxt  = base;
    if (sum > WRAP_LIMIT) begin
      nxt.epoch = base.epoch + WFQ_OVF_WIDTH'(1);
      nxt.round = sum[RW-1:0];
    end else if ((base.epoch == vt.epoch) && (sum < (RW+2)'(vt.round))) begin
      nxt.round = vt.round;
    end else begin
      nxt.round = sum[RW-1:0];
    end
    return nxt;
  endfunction

  wfq_state_t  vt_state;
  logic [RW:0] inc_w;

  assign vt_state   = {vt_epoch, vt_round};
  assign inc_w      = (RW+1)'(quotient) + (RW+1)'(remain != '0);
  assign next_state = advance_tag(cls_state, vt_state, inc_w);

endmodule

// File: rtl/wfq_rank_pipe.sv
// Pipelined, back-pressured WFQ rank calculator.
// S0 reads the class finish tag (with clear/bypass forwarding), S1 computes
// the new tag and writes it back while registering the PIFO rank word.
// Optional macro WFQ_STATE_READ_EN adds a registered debug read port on the
// class-state array.
module wfq_rank_pipe
  import wfq_pkg::*;
#(
  parameter int CLASS_WIDTH  = WFQ_CLASS_WIDTH,
  parameter int QUOT_WIDTH   = WFQ_QUOT_WIDTH,
  parameter int OVF_WIDTH    = WFQ_OVF_WIDTH,
  parameter int ROUND_WIDTH  = WFQ_ROUND_WIDTH,
  parameter int ADDR_WIDTH   = WFQ_ADDR_WIDTH,
  parameter int RESULT_WIDTH = WFQ_RESULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  wfq_rank_pipe_if.slave         bus,
  input  logic [OVF_WIDTH-1:0]   vt_epoch,
  input  logic [ROUND_WIDTH-1:0] vt_round,
  input  logic                   clr_valid,
  input  logic [CLASS_WIDTH-1:0] clr_class_id
`ifdef WFQ_STATE_READ_EN
  ,
  input  logic [CLASS_WIDTH-1:0]           dbg_rd_class_id,
  output logic [OVF_WIDTH+ROUND_WIDTH-1:0] dbg_rd_data
`endif
);

  localparam int NUM_CLASSES = 2 ** CLASS_WIDTH;

  if (RESULT_WIDTH != 1 + OVF_WIDTH + ROUND_WIDTH + ADDR_WIDTH) begin : g_bad_result_width
    $error("wfq_rank_pipe: RESULT_WIDTH must equal 1+OVF_WIDTH+ROUND_WIDTH+ADDR_WIDTH");
  end
  if ((OVF_WIDTH != WFQ_OVF_WIDTH) || (ROUND_WIDTH != WFQ_ROUND_WIDTH) ||
      (ADDR_WIDTH != WFQ_ADDR_WIDTH)) begin : g_bad_tag_width
    $error("wfq_rank_pipe: tag field widths must match wfq_pkg");
  end

  logic                    adv;
  wfq_state_t              state_mem [NUM_CLASSES];
  wfq_state_t              vt_now;
  wfq_state_t              rd_state_p0;

  logic                    vld_p1;
  logic [CLASS_WIDTH-1:0]  class_p1;
  logic [QUOT_WIDTH-1:0]   quot_p1;
  logic [QUOT_WIDTH-1:0]   remain_p1;
  wfq_state_t              state_p1;
  wfq_state_t              vt_p1;
  wfq_state_t              next_p1;

  logic                    vld_p2;
  logic [RESULT_WIDTH-1:0] data_p2;

  // The whole pipe moves together; a full, unaccepted output freezes it.
  assign adv           = ~vld_p2 | bus.resp_ready;
  assign bus.req_ready = adv;
  assign bus.resp_valid = vld_p2;
  assign bus.resp_data  = data_p2;
  assign vt_now        = {vt_epoch, vt_round};

  // S0: class tag read; a same-cycle clear beats the in-flight S1 result.
  always_comb begin
    rd_state_p0 = state_mem[bus.req_class_id];
    if (clr_valid && (clr_class_id == bus.req_class_id)) begin
      rd_state_p0 = vt_now;
    end else if (vld_p1 && (class_p1 == bus.req_class_id)) begin
      rd_state_p0 = next_p1;
    end
  end

  // S0 -> S1 boundary: stage-1 occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= bus.req_valid;
    end
  end

  // S0 -> S1 boundary: request fields, tag snapshot and virtual time.
  always_ff @(posedge clk) begin
    if (adv && bus.req_valid) begin
      class_p1  <= bus.req_class_id;
      quot_p1   <= bus.req_quotient;
      remain_p1 <= bus.req_remain;
      state_p1  <= rd_state_p0;
      vt_p1     <= vt_now;
    end
  end

  wfq_rank_calc #(
    .QUOT_WIDTH (QUOT_WIDTH)
  ) u_calc (
    .cls_state  (state_p1),
    .vt_epoch   (vt_p1.epoch),
    .vt_round   (vt_p1.round),
    .quotient   (quot_p1),
    .remain     (remain_p1),
    .next_state (next_p1)
  );

  // S1 -> S2 boundary: registered rank word towards the PIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= pack_rank(next_p1);
      end
    end
  end

  // Class-state array: S1 writeback, overridden by a clear of the same class.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        state_mem[i] <= '0;
      end
    end else begin
      if (adv && vld_p1 && !(clr_valid && (clr_class_id == class_p1))) begin
        state_mem[class_p1] <= next_p1;
      end
      if (clr_valid) begin
        state_mem[clr_class_id] <= vt_now;
      end
    end
  end

`ifdef WFQ_STATE_READ_EN
  // Debug read of the array, returning the value held before this edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dbg_rd_data <= '0;
    end else begin
      dbg_rd_data <= state_mem[dbg_rd_class_id];
    end
  end
`endif

endmodule

// File: tb/tb_wfq_rank_pipe.sv
// Scoreboard bench for wfq_rank_pipe: directed scenarios followed by random
// traffic, checked against a transaction-level model of the class tags.
module tb_wfq_rank_pipe;
  import wfq_pkg::*;

  localparam int NCLS = CLASS_COUNT;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [WFQ_OVF_WIDTH-1:0]   vt_epoch = '0;
  logic [WFQ_ROUND_WIDTH-1:0] vt_round = '0;
  logic                       clr_valid = 1'b0;
  logic [WFQ_CLASS_WIDTH-1:0] clr_class_id = '0;

  wfq_rank_pipe_if bus ();

`ifdef WFQ_STATE_READ_EN
  logic [WFQ_CLASS_WIDTH-1:0]               dbg_rd_class_id;
  logic [WFQ_OVF_WIDTH+WFQ_ROUND_WIDTH-1:0] dbg_rd_data;
  assign dbg_rd_class_id = '0;
`endif

  wfq_rank_pipe dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .vt_epoch     (vt_epoch),
    .vt_round     (vt_round),
    .clr_valid    (clr_valid),
    .clr_class_id (clr_class_id)
`ifdef WFQ_STATE_READ_EN
    ,
    .dbg_rd_class_id (dbg_rd_class_id),
    .dbg_rd_data     (dbg_rd_data)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: per-class tag, one request awaiting its commit,
  // and whether a rank is presented at the output.
  int          st_e [NCLS];
  int          st_r [NCLS];
  bit          pend_v = 0;
  int          pend_cls, pend_e, pend_r;
  bit          outv_m = 0;
  bit          acc_m = 0;
  bit          adv_m = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rank_of(input int e, input int r);
    return {1'b1, 1'(e), 18'(r), 12'b0};
  endfunction

  // New finish tag from the arithmetic rules, in plain integers.
  function automatic void next_tag(input int ce, input int cr, input int ve, input int vr,
                                   input int q, input int rm, output int ne, output int nr);
    int be, br, s;
    if (ce != ve && vr < cr) begin be = ve; br = vr; end
    else begin be = ce; br = cr; end
    s = br + q + ((rm != 0) ? 1 : 0);
    if (s > 262143) begin ne = (be + 1) % 2; nr = s - 262144; end
    else if (be == ve && s < vr) begin ne = be; nr = vr; end
    else begin ne = be; nr = s; end
  endfunction

  // Effect of the coming clock edge, in event order: a held result commits,
  // a clear lands on top of it, then a newly accepted request reads the tag.
  task automatic model_edge();
    int ne, nr, c;
    acc_m = 0;
    if (!rstn) begin
      for (int i = 0; i < NCLS; i++) begin st_e[i] = 0; st_r[i] = 0; end
      pend_v = 0; outv_m = 0; adv_m = 0;
      exp_q.delete();
      return;
    end
    adv_m = !outv_m || bus.resp_ready;
    if (adv_m) begin
      if (pend_v) begin st_e[pend_cls] = pend_e; st_r[pend_cls] = pend_r; end
      outv_m = pend_v;
      pend_v = 0;
    end
    if (clr_valid) begin
      st_e[clr_class_id] = int'(vt_epoch);
      st_r[clr_class_id] = int'(vt_round);
    end
    if (adv_m && bus.req_valid) begin
      c = int'(bus.req_class_id);
      next_tag(st_e[c], st_r[c], int'(vt_epoch), int'(vt_round),
               int'(bus.req_quotient), int'(bus.req_remain), ne, nr);
      exp_q.push_back(rank_of(ne, nr));
      pend_v = 1; pend_cls = c; pend_e = ne; pend_r = nr;
      acc_m = 1;
    end
  endtask

  // One clock: apply inputs, update the model, check handshake and output.
  task automatic drive(input bit rv, input int cls, input int q, input int r,
                       input bit cv, input int ccls, input bit rr);
    bus.req_valid    = rv;
    bus.req_class_id = 5'(cls);
    bus.req_quotient = 16'(q);
    bus.req_remain   = 16'(r);
    clr_valid        = cv;
    clr_class_id     = 5'(ccls);
    bus.resp_ready   = rr && rstn;
    model_edge();
    #2;
    if (rstn) check("req_ready", 32'(bus.req_ready), 32'(adv_m));
    @(posedge clk);
    #1;
    check("resp_valid", 32'(bus.resp_valid), 32'(outv_m));
    if (outv_m) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp_present actual=valid required=no_pending_rank t=%0t", $time);
      end else begin
        check("resp_data_held", bus.resp_data, exp_q[0]);
      end
    end else if (!rstn) begin
      check("reset_resp_data", bus.resp_data, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every accepted rank must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp_extra actual=%0h required=none t=%0t", bus.resp_data, $time);
        end else begin
          check("resp_data", bus.resp_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit cur_v;
    int cur_cls, cur_q, cur_r;
    cur_v = 0; cur_cls = 0; cur_q = 0; cur_r = 0;

    @(posedge clk);
    #1;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    rstn = 1'b1;
    idle(1);

    // Basic rank, then a second request on the same class with a remainder.
    drive(1, 3, 10, 0, 0, 0, 1);
    idle(3);
    drive(1, 3, 5, 1, 0, 0, 1);
    idle(3);

    // Back-to-back same class relies on forwarding the S1 result.
    drive(1, 7, 4, 0, 0, 0, 1);
    drive(1, 7, 4, 0, 0, 0, 1);
    idle(3);

    // Wrap: class 1 built up to 262140, then +10 crosses ROUND_MAX.
    for (int i = 0; i < 4; i++) drive(1, 1, 65535, 0, 0, 0, 1);
    drive(1, 1, 10, 0, 0, 0, 1);
    idle(3);

    // Stale class adopts virtual time; then lag clamp after a clear to {1,10}.
    drive(1, 2, 200, 0, 0, 0, 1);
    idle(2);
    vt_epoch = 1'b1; vt_round = 18'd50;
    drive(1, 2, 3, 0, 0, 0, 1);
    idle(2);
    vt_round = 18'd10;
    drive(0, 0, 0, 0, 1, 2, 1);
    vt_round = 18'd100;
    drive(1, 2, 5, 0, 0, 0, 1);
    idle(3);
    vt_epoch = 1'b0; vt_round = 18'd0;

    // Back-pressure: two ranks fill the pipe, three stalled cycles, release.
    drive(1, 9, 2, 0, 0, 0, 0);
    drive(1, 9, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 10, 4, 0, 0, 0, 0);
    drive(1, 10, 4, 0, 0, 0, 1);
    drive(1, 9, 1, 0, 0, 0, 1);
    idle(4);

    // Clear landing on the S1 writeback of class 4, then a probe of class 4.
    drive(1, 4, 7, 0, 0, 0, 1);
    vt_round = 18'd500;
    drive(0, 0, 0, 0, 1, 4, 1);
    drive(1, 4, 1, 0, 0, 0, 1);
    idle(3);
    // Clear on the S0 read, and clear beating the forwarded S1 result.
    vt_round = 18'd40;
    drive(1, 5, 3, 0, 1, 5, 1);
    drive(1, 6, 2, 0, 0, 0, 1);
    vt_round = 18'd90;
    drive(1, 6, 2, 0, 1, 6, 1);
    idle(3);

    // Random traffic on a few classes with clears, vt moves and stalls.
    for (int i = 0; i < 500; i++) begin
      if (!cur_v && $urandom_range(0, 3) != 0) begin
        cur_v   = 1;
        cur_cls = int'($urandom_range(0, 7));
        cur_q   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 300));
        cur_r   = int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 9) == 0) begin
        vt_epoch = 1'($urandom_range(0, 1));
        vt_round = 18'($urandom_range(0, 3000));
      end
      drive(cur_v, cur_cls, cur_q, cur_r, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      if (acc_m) cur_v = 0;
    end

    // Reset with requests in flight, then probe classes for zeroed state.
    vt_epoch = 1'b0; vt_round = 18'd0;
    drive(1, 3, 5, 0, 0, 0, 1);
    drive(1, 7, 5, 0, 0, 0, 0);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    drive(1, 3, 10, 0, 0, 0, 1);
    drive(1, 7, 4, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 1);
    drive(1, 4, 2, 1, 0, 0, 1);

    // Drain with a bounded budget; everything expected must have appeared.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || outv_m); i++) idle(1);
    idle(2);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wfq_rank_pipe.md
Name: wfq_rank_pipe

Overview:
- Pipelined, back-pressured WFQ rank calculator. It is the successor to the single-request FSM rank engine.
- Accepts one request per cycle, keeps per-class {epoch, round} finish-tag state, and emits a PIFO rank word.
- Sits between the per-packet divider (quotient/remainder of pkt_len/weight) and the PIFO insert port.
- Adds a valid/ready handshake, same-class bypass, per-class clear, and advance-from-virtual-time on stale classes.

Parameters:
- CLASS_WIDTH, 5, class id bits; CLASS_COUNT = 2**CLASS_WIDTH.
- QUOT_WIDTH, 16, width of req_quotient and req_remain.
- OVF_WIDTH, 1, epoch (wrap) counter bits.
- ROUND_WIDTH, 18, round bits; ROUND_MAX = 2**ROUND_WIDTH-1.
- ADDR_WIDTH, 12, zero padding at the LSBs of the rank word.
- RESULT_WIDTH, 32, must equal 1+OVF_WIDTH+ROUND_WIDTH+ADDR_WIDTH. The mismatch check is a simulation $error at elaboration.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_class_id  in  CLASS_WIDTH  class.
- req_quotient  in  QUOT_WIDTH  pkt_len/weight quotient.
- req_remain  in  QUOT_WIDTH  pkt_len/weight remainder.
- vt_epoch  in  OVF_WIDTH  epoch of the last dequeued PIFO entry.
- vt_round  in  ROUND_WIDTH  round of the last dequeued PIFO entry.
- clr_valid  in  1  reset one class's state.
- clr_class_id  in  CLASS_WIDTH  class to clear.
- resp_valid  out  1  rank valid.
- resp_ready  in  1  downstream accepts.
- resp_data  out  RESULT_WIDTH  {1'b1, epoch, round, ADDR_WIDTH'b0}.

Behaviour:
- Reset (rstn=0 at posedge clk):
  - resp_valid=0, resp_data=0.
  - Stage-1 valid=0.
  - All class states {0,0}.
  - req_ready=1 in the cycle after reset.
  - An in-flight request at reset is discarded.
- Pipeline advance: adv = ~resp_valid | resp_ready. req_ready = adv. When adv=0 every stage holds and no state is written.
- S0 (accept cycle T): read the class state, or the bypassed value (see bypass rules). Register into S1 with the class and request fields, and sample vt.
- S1 (cycle T+1), compute:
  - inc = quotient + (remain!=0), ROUND_WIDTH+1 bits, zero-extended.
  - stale = (cls_epoch != vt_epoch) && (vt_round < cls_round).
  - base = stale ? {vt_epoch, vt_round} : cls state.
  - sum = base_round + inc, ROUND_WIDTH+2 bits.
  - If sum > ROUND_MAX: epoch = base_epoch+1 (mod 2**OVF_WIDTH), round = sum - (ROUND_MAX+1).
  - Else if base_epoch == vt_epoch and sum < vt_round: round = vt_round (lag clamp), epoch unchanged.
  - Else round = sum.
  - On adv: register resp_data and write back the class state.
- Latency: resp_valid rises in cycle T+2 when there is no stall. Throughput is 1 per cycle.
- Bypass: if S1 is valid and holds the same class as S0, S0 takes the S1 computed next-state, not the array value.
- Clear: sets state[clr_class_id] = {vt_epoch, vt_round}. It is not gated by adv.
  - Same cycle as S1 writeback to the same class: clear wins; the S1 response is still emitted.
  - Same cycle as S0 read of the same class: S0 reads the cleared value, and clear takes priority over the S1 bypass.
- Responses are never dropped or duplicated. Order is preserved.

Optional Feature:
- Macro: WFQ_STATE_READ_EN.
- Defined:
  - Adds input dbg_rd_class_id [CLASS_WIDTH] and output dbg_rd_data [OVF_WIDTH+ROUND_WIDTH].
  - Output is a registered read of the array, 1-cycle latency, reset 0.
  - Reads the pre-write value in a same-cycle write.
- Undefined: ports and logic absent.

Decomposition:
- Package wfq_pkg:
  - Localparams CLASS_COUNT and ROUND_MAX.
  - Struct wfq_state_t {epoch, round}.
  - Rank-word packing function.
- Sub-module wfq_rank_calc: purely combinational S1 arithmetic (stale, wrap, clamp), instantiated once.

Test Plan:
- Reset, then class 3 with q=10, r=0, vt={0,0} -> resp {1,0,10,0} at T+2. Next class 3 request with q=5, r=1 -> round 16.
- Back-to-back class 7 in consecutive cycles, q=4, r=0 each, from state 0 -> rounds 4 then 8. This exercises the bypass.
- Wrap: class 1 state {0,262140}, q=10, r=0 -> epoch 1, round 6.
- Stale: class 2 state {0,200}, vt={1,50}, q=3, r=0 -> {1,53}. Lag clamp: class 2 state {1,10}, vt={1,100}, q=5 -> {1,100}.
- Back-pressure: hold resp_ready=0 for 3 cycles with requests offered. Required: req_ready=0, resp_data stable, no state change; after release, all responses in order.
- Clear of class 4 in the same cycle as S1 writeback of class 4 -> response emitted, state[4]=vt. Mid-pipeline reset -> resp_valid=0 the next cycle and all states zero.
